// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for instr_sequencer: word classes, class field position,
// FSM state encoding and the per-class hold-time lookup.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        CLS_NOP   = 2'b00,
        CLS_ALU   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } instr_class_e;

    localparam int CLASS_MSB = 19;
    localparam int CLASS_LSB = 18;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CNT_W = 8;

    // A nonzero class-00 word is treated as ALU, so it shares the ALU hold time.
    function automatic logic [CNT_W-1:0] hold_cycles(input logic [1:0] cls,
                                                     input int alu_hold,
                                                     input int store_hold,
                                                     input int load_hold);
        int h;
        case (cls)
            CLS_LOAD:  h = load_hold;
            CLS_STORE: h = store_hold;
            default:   h = alu_hold;
        endcase
        return CNT_W'(h);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load and instruction-stream bundle between instr_sequencer and its user.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 4
);
    logic                   prog_we;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_wdata;
    logic                   start;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   done;

    modport master (
        output prog_we, prog_addr, prog_wdata, start,
        input  instruction, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start,
        output instruction, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: one synchronous write port, one registered read port, no reset.
module instr_sequencer_prog_mem #(
    parameter int WIDTH  = 20,
    parameter int A_BITS = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [A_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [A_BITS-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem_q [2**A_BITS];
    logic [WIDTH-1:0] rd_q;

    // Write-first: a word loaded on the same edge as start must be the one fetched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rd_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end

    assign rdata = rd_q;
endmodule

// File: rtl/instr_sequencer.sv
// Walks the program store from address 0 after start, presenting each word for
// its class hold time with a one-cycle zero gap between words.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 4,
    parameter int ALU_HOLD    = 4,
    parameter int STORE_HOLD  = 3,
    parameter int LOAD_HOLD   = 4
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);
    localparam logic [PC_BITS-1:0] PC_LAST = '1;

    logic [1:0]             state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic [CNT_W-1:0]       fetch_hold;
    logic                   mem_we;

    assign mem_we = bus.prog_we && (state_q == ST_IDLE);

    // Read address follows pc_d so the word is already registered while in FETCH.
    instr_sequencer_prog_mem #(
        .WIDTH  (INSTR_WIDTH),
        .A_BITS (PC_BITS)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_wdata),
        .raddr (pc_d),
        .rdata (rd_data)
    );

    assign fetch_hold = hold_cycles(rd_data[CLASS_MSB:CLASS_LSB], ALU_HOLD, STORE_HOLD, LOAD_HOLD)
                        - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (rd_data == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                    instr_d = rd_data;
                    cnt_d   = fetch_hold;
                end
            end
            ST_ISSUE: begin
                instr_d = instr_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pc_q == PC_LAST) begin
                    state_d = ST_DONE;
                    instr_d = '0;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + PC_BITS'(1);
                    instr_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign bus.done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a per-run trace model built from the
// program contents is compared cycle by cycle against the outputs.
module tb_instr_sequencer;

    typedef struct packed {
        logic [19:0] instr;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assert_cnt = 0;
    int   fail_cnt   = 0;
    logic [19:0] prog_m [16];

    always #5 clk = ~clk;

    instr_sequencer_if #(.INSTR_WIDTH(20), .PC_BITS(4)) bus ();

    instr_sequencer #(
        .INSTR_WIDTH (20),
        .PC_BITS     (4),
        .ALU_HOLD    (4),
        .STORE_HOLD  (3),
        .LOAD_HOLD   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample_out();
        obs_t o;
        o.instr = bus.instruction;
        o.pc    = bus.pc;
        o.busy  = bus.busy;
        o.done  = bus.done;
        return o;
    endfunction

    function automatic int hold_of(input logic [19:0] w);
        case (w[19:18])
            2'b11:   return 3;
            2'b10:   return 4;
            default: return 4;
        endcase
    endfunction

    function automatic logic [19:0] rand_word();
        logic [19:0] w;
        w = 20'($urandom);
        if (w == 20'h0) w = 20'h1;
        return w;
    endfunction

    task automatic load_word(input logic [3:0] a, input logic [19:0] d);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = a;
        bus.prog_wdata = d;
        prog_m[a]      = d;
        @(posedge clk); #1;
        bus.prog_we    = 1'b0;
    endtask

    // Starts a run and compares every cycle against the expected trace.
    // inject_at: trace index at which start/prog_we are pulsed (ignored by DUT).
    // abort_at:  trace index after which rst is pulsed and the run ends.
    task automatic run_and_compare(input string tag, input int inject_at, input int abort_at,
                                   input bit wr_with_start, input logic [19:0] wr_data);
        obs_t exp_q[$];
        obs_t got;
        obs_t e;
        int   p;
        logic [19:0] w;
        if (wr_with_start) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = 4'd0;
            bus.prog_wdata = wr_data;
            prog_m[0]      = wr_data;
        end
        // Expected trace: fetch gap, then each word for its hold time, until HALT or the last address.
        p = 0;
        exp_q.push_back('{instr: 20'h0, pc: 4'd0, busy: 1'b1, done: 1'b0});
        forever begin
            w = prog_m[p];
            if (w == 20'h0) begin
                exp_q.push_back('{instr: 20'h0, pc: 4'(p), busy: 1'b0, done: 1'b1});
                break;
            end
            for (int h = 0; h < hold_of(w); h++)
                exp_q.push_back('{instr: w, pc: 4'(p), busy: 1'b1, done: 1'b0});
            if (p == 15) begin
                exp_q.push_back('{instr: 20'h0, pc: 4'(p), busy: 1'b0, done: 1'b1});
                break;
            end
            p++;
            exp_q.push_back('{instr: 20'h0, pc: 4'(p), busy: 1'b1, done: 1'b0});
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = sample_out();
            e   = exp_q[i];
            assert_cnt++;
            if (got !== e) begin
                fail_cnt++;
                $display("FAIL %s cycle %0d: got instr=%h pc=%0d busy=%b done=%b, expected instr=%h pc=%0d busy=%b done=%b",
                         tag, i, got.instr, got.pc, got.busy, got.done, e.instr, e.pc, e.busy, e.done);
            end
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                got = sample_out();
                assert_cnt++;
                if (got !== obs_t'(0)) begin
                    fail_cnt++;
                    $display("FAIL %s abort: got instr=%h pc=%0d busy=%b done=%b, expected all zero",
                             tag, got.instr, got.pc, got.busy, got.done);
                end
                $display("%s: aborted by rst at cycle %0d", tag, i);
                return;
            end
            if (i == inject_at) begin
                bus.start      = 1'b1;
                bus.prog_we    = 1'b1;
                bus.prog_addr  = 4'($urandom);
                bus.prog_wdata = rand_word();
            end
            @(posedge clk); #1;
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
        end
        got = sample_out();
        assert_cnt++;
        if (got !== obs_t'({20'h0, 4'(p), 1'b0, 1'b0})) begin
            fail_cnt++;
            $display("FAIL %s idle: got instr=%h pc=%0d busy=%b done=%b, expected instr=0 pc=%0d busy=0 done=0",
                     tag, got.instr, got.pc, got.busy, got.done, p);
        end
        $display("%s: run of %0d cycles, final pc=%0d", tag, exp_q.size(), p);
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = sample_out();
        assert_cnt++;
        if (got.instr !== 20'h0) begin fail_cnt++; $display("FAIL reset instruction: got %h expected 0", got.instr); end
        assert_cnt++;
        if (got.pc !== 4'd0) begin fail_cnt++; $display("FAIL reset pc: got %0d expected 0", got.pc); end
        assert_cnt++;
        if (got.busy !== 1'b0) begin fail_cnt++; $display("FAIL reset busy: got %b expected 0", got.busy); end
        assert_cnt++;
        if (got.done !== 1'b0) begin fail_cnt++; $display("FAIL reset done: got %b expected 0", got.done); end
        rst = 1'b0;
        $display("test_reset: outputs checked after 3 reset cycles");
    endtask

    task automatic load_spec_program();
        load_word(4'd0, 20'b01000111000000000000);
        load_word(4'd1, 20'b01110010000000000001);
        load_word(4'd2, 20'b11011000000011110000);
        load_word(4'd3, 20'b10111000000011110000);
        load_word(4'd4, 20'h0);
    endtask

    task automatic test_program_run();
        load_spec_program();
        run_and_compare("program_run", -1, -1, 1'b0, 20'h0);
    endtask

    task automatic test_full_store();
        for (int a = 0; a < 16; a++)
            load_word(4'(a), {2'b01, 18'($urandom) | 18'h1});
        run_and_compare("full_store", -1, -1, 1'b0, 20'h0);
    endtask

    task automatic test_ignored_controls();
        int halt_pos;
        halt_pos = int'($urandom_range(3, 8));
        for (int a = 0; a < 16; a++)
            load_word(4'(a), (a == halt_pos) ? 20'h0 : rand_word());
        run_and_compare("ignored_ctrl", 2, -1, 1'b0, 20'h0);
        run_and_compare("ignored_ctrl_replay", -1, -1, 1'b0, 20'h0);
    endtask

    task automatic test_reset_mid_run();
        load_spec_program();
        run_and_compare("reset_mid_run", -1, 7, 1'b0, 20'h0);
        run_and_compare("reset_replay", -1, -1, 1'b0, 20'h0);
    endtask

    task automatic test_halt_at_zero();
        load_word(4'd0, rand_word());
        load_word(4'd1, 20'h0);
        run_and_compare("halt_at_zero", -1, -1, 1'b1, 20'h0);
        run_and_compare("write_with_start", -1, -1, 1'b1, rand_word());
    endtask

    task automatic test_random_programs();
        int halt_pos;
        for (int r = 0; r < 5; r++) begin
            halt_pos = int'($urandom_range(0, 16));
            for (int a = 0; a < 16; a++)
                load_word(4'(a), (a == halt_pos) ? 20'h0 : rand_word());
            run_and_compare($sformatf("random_%0d", r), -1, -1, 1'b0, 20'h0);
        end
    endtask

    task automatic test_back_to_back();
        load_spec_program();
        run_and_compare("back_to_back_a", -1, -1, 1'b0, 20'h0);
        run_and_compare("back_to_back_b", -1, -1, 1'b0, 20'h0);
    endtask

    initial begin
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.start      = 1'b0;
        test_reset();
        test_program_run();
        test_full_store();
        test_ignored_controls();
        test_reset_mid_run();
        test_halt_at_zero();
        test_random_programs();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
